// File: rtl/pipeline_ctrl_if.sv
// Hazard/flow control bundle between the pipeline stages and pipeline_ctrl.
//   Inputs to the controller : icache/muldiv/dcache ready, EX redirect target,
//                              per-stage block flags and the EX branch flag.
//   Outputs of the controller: one control code per stage and cache, plus the
//                              redirect target for the PC stage.
//   master modport: the controller side.  slave modport: the pipeline side.
interface pipeline_ctrl_if #(
   parameter int unsigned CTRL_W = 2,
   parameter int unsigned ADDR_W = 32
);

   // Status from the pipeline and caches
   logic              icache_ready_i;
   logic              muldiv_ready_i;
   logic              dcache_ready_i;
   logic [ADDR_W-1:0] ex_pc_new_i;
   logic              if_id_block_flag_i;
   logic              ex_branch_flag_i;
   logic              ex_block_flag_i;
   logic              mem_block_flag_i;

   // Control codes back to the pipeline and caches
   logic [CTRL_W-1:0] ctrl_signal_pc_o;
   logic [CTRL_W-1:0] ctrl_signal_if_id_o;
   logic [CTRL_W-1:0] ctrl_signal_id_ex_o;
   logic [CTRL_W-1:0] ctrl_signal_muldiv_o;
   logic [CTRL_W-1:0] ctrl_signal_ex_mem_o;
   logic [CTRL_W-1:0] ctrl_signal_mem_wb_o;
   logic [ADDR_W-1:0] ctrl_to_pc_new_o;
   logic [CTRL_W-1:0] ctrl_signal_icache_o;
   logic [CTRL_W-1:0] ctrl_signal_dcache_o;

   modport master (
      input  icache_ready_i, muldiv_ready_i, dcache_ready_i, ex_pc_new_i,
             if_id_block_flag_i, ex_branch_flag_i, ex_block_flag_i,
             mem_block_flag_i,
      output ctrl_signal_pc_o, ctrl_signal_if_id_o, ctrl_signal_id_ex_o,
             ctrl_signal_muldiv_o, ctrl_signal_ex_mem_o, ctrl_signal_mem_wb_o,
             ctrl_to_pc_new_o, ctrl_signal_icache_o, ctrl_signal_dcache_o
   );

   modport slave (
      output icache_ready_i, muldiv_ready_i, dcache_ready_i, ex_pc_new_i,
             if_id_block_flag_i, ex_branch_flag_i, ex_block_flag_i,
             mem_block_flag_i,
      input  ctrl_signal_pc_o, ctrl_signal_if_id_o, ctrl_signal_id_ex_o,
             ctrl_signal_muldiv_o, ctrl_signal_ex_mem_o, ctrl_signal_mem_wb_o,
             ctrl_to_pc_new_o, ctrl_signal_icache_o, ctrl_signal_dcache_o
   );

endinterface

// File: rtl/pipeline_ctrl.sv
// Central hazard/flow controller for the 5-stage RV32 pipeline.
// Each cycle arbitrates MEM, EX and fetch stalls against EX redirects and
// drives one control code per stage/cache (RUN/STALL/FLUSH/JUMP) plus the PC
// redirect target. A redirect that the icache could not take is remembered
// and replayed until the icache is ready.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - pipeline_ctrl_if.master: status inputs and control-code outputs
// Control-code outputs are combinational from the inputs and the pending
// redirect state.
module pipeline_ctrl #(
   parameter int unsigned       CTRL_W   = 2,
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   pipeline_ctrl_if.master      bus
);

   // Control codes
   localparam logic [CTRL_W-1:0] RUN   = CTRL_W'(2'b00);
   localparam logic [CTRL_W-1:0] STALL = CTRL_W'(2'b01);
   localparam logic [CTRL_W-1:0] FLUSH = CTRL_W'(2'b10);
   localparam logic [CTRL_W-1:0] JUMP  = CTRL_W'(2'b11);

   // Redirect-tracking states
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_PEND = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;

   logic [CTRL_W-1:0] pc_c, if_id_c, id_ex_c, muldiv_c;
   logic [CTRL_W-1:0] ex_mem_c, mem_wb_c, icache_c, dcache_c;
   logic [ADDR_W-1:0] pc_new_c;

   logic mem_stall_c;
   logic fetch_stall_c;

   // MULDIV readiness is already folded into ex_block_flag_i by EX
   logic unused_muldiv_ready;
   assign unused_muldiv_ready = bus.muldiv_ready_i;

   assign mem_stall_c   = bus.mem_block_flag_i | ~bus.dcache_ready_i;
   assign fetch_stall_c = ~bus.icache_ready_i | bus.if_id_block_flag_i;

   // State register for the pending redirect
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pend_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         pend_pc_q <= pend_pc_d;
      end
   end

   // Priority arbitration: reset, MEM stall, EX stall, branch, pending
   // redirect, fetch stall, run
   always_comb begin
      state_d   = state_q;
      pend_pc_d = pend_pc_q;
      pc_c      = RUN;
      if_id_c   = RUN;
      id_ex_c   = RUN;
      muldiv_c  = RUN;
      ex_mem_c  = RUN;
      mem_wb_c  = RUN;
      icache_c  = RUN;
      dcache_c  = RUN;
      pc_new_c  = RESET_PC;

      if (rst) begin
         state_d   = S_IDLE;
         pend_pc_d = '0;
         pc_c      = STALL;
         if_id_c   = FLUSH;
         id_ex_c   = FLUSH;
         muldiv_c  = FLUSH;
         ex_mem_c  = FLUSH;
         mem_wb_c  = FLUSH;
         icache_c  = FLUSH;
         dcache_c  = FLUSH;
      end else if (mem_stall_c) begin
         // Whole front freezes; the retiring slot gets a bubble. EX is frozen,
         // so a branch flag here re-presents next cycle.
         pc_c      = STALL;
         if_id_c   = STALL;
         id_ex_c   = STALL;
         muldiv_c  = STALL;
         ex_mem_c  = STALL;
         mem_wb_c  = FLUSH;
         icache_c  = STALL;
         dcache_c  = STALL;
      end else if (bus.ex_block_flag_i) begin
         // Front holds while MULDIV grinds; bubble into MEM
         pc_c      = STALL;
         if_id_c   = STALL;
         id_ex_c   = STALL;
         icache_c  = STALL;
         ex_mem_c  = FLUSH;
      end else if (bus.ex_branch_flag_i) begin
         // Fresh redirect always wins over (and replaces) a pending one
         pc_c      = JUMP;
         pc_new_c  = bus.ex_pc_new_i;
         if_id_c   = FLUSH;
         id_ex_c   = FLUSH;
         icache_c  = FLUSH;
         dcache_c  = FLUSH;
         pend_pc_d = bus.ex_pc_new_i;
         state_d   = bus.icache_ready_i ? S_IDLE : S_PEND;
      end else if (state_q == S_PEND) begin
         // Replay the remembered target until the icache takes it
         pc_c      = JUMP;
         pc_new_c  = pend_pc_q;
         if_id_c   = FLUSH;
         icache_c  = FLUSH;
         if (bus.icache_ready_i) begin
            state_d = S_IDLE;
         end
      end else if (fetch_stall_c) begin
         pc_c      = STALL;
         icache_c  = STALL;
         if_id_c   = FLUSH;
      end
   end

   assign bus.ctrl_signal_pc_o     = pc_c;
   assign bus.ctrl_signal_if_id_o  = if_id_c;
   assign bus.ctrl_signal_id_ex_o  = id_ex_c;
   assign bus.ctrl_signal_muldiv_o = muldiv_c;
   assign bus.ctrl_signal_ex_mem_o = ex_mem_c;
   assign bus.ctrl_signal_mem_wb_o = mem_wb_c;
   assign bus.ctrl_to_pc_new_o     = pc_new_c;
   assign bus.ctrl_signal_icache_o = icache_c;
   assign bus.ctrl_signal_dcache_o = dcache_c;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios followed by
// random stimulus, each cycle compared against a table-driven reference.
module tb_pipeline_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   passes = 0;
   int   step_no = 0;

   // Reference state: at most one remembered redirect target
   logic [31:0] pend_q[$];

   pipeline_ctrl_if bus ();

   pipeline_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Rule rows list codes for pc,if_id,id_ex,muldiv,ex_mem,mem_wb,icache,dcache
   function automatic logic [15:0] rule_row(input int rule);
      case (rule)
         0: rule_row = {2'b01,2'b10,2'b10,2'b10,2'b10,2'b10,2'b10,2'b10}; // reset
         1: rule_row = {2'b01,2'b01,2'b01,2'b01,2'b01,2'b10,2'b01,2'b01}; // mem stall
         2: rule_row = {2'b01,2'b01,2'b01,2'b00,2'b10,2'b00,2'b01,2'b00}; // ex stall
         3: rule_row = {2'b11,2'b10,2'b10,2'b00,2'b00,2'b00,2'b10,2'b10}; // branch
         4: rule_row = {2'b11,2'b10,2'b00,2'b00,2'b00,2'b00,2'b10,2'b00}; // pending
         5: rule_row = {2'b01,2'b10,2'b00,2'b00,2'b00,2'b00,2'b01,2'b00}; // fetch stall
         default: rule_row = 16'h0000;                                   // run
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s step=%0d observed=%h expected=%h", tag, step_no, obs, exp);
   endtask

   // Apply one cycle of inputs, compare outputs, then advance the model
   task automatic step(input logic r, input logic br, input logic [31:0] tgt,
                       input logic ic_rdy, input logic dc_rdy,
                       input logic ifb, input logic exb, input logic memb);
      int          rule;
      logic [15:0] row;
      logic [31:0] exp_pc;
      logic [1:0]  obs[8];
      string       names[8];
      names = '{"pc","if_id","id_ex","muldiv","ex_mem","mem_wb","icache","dcache"};
      @(negedge clk);
      step_no++;
      rst                    = r;
      bus.ex_branch_flag_i   = br;
      bus.ex_pc_new_i        = tgt;
      bus.icache_ready_i     = ic_rdy;
      bus.dcache_ready_i     = dc_rdy;
      bus.if_id_block_flag_i = ifb;
      bus.ex_block_flag_i    = exb;
      bus.mem_block_flag_i   = memb;
      bus.muldiv_ready_i     = 1'($urandom_range(0, 1));
      #1;
      if (r)                         rule = 0;
      else if (memb || !dc_rdy)      rule = 1;
      else if (exb)                  rule = 2;
      else if (br)                   rule = 3;
      else if (pend_q.size() != 0)   rule = 4;
      else if (!ic_rdy || ifb)       rule = 5;
      else                           rule = 6;
      row    = rule_row(rule);
      exp_pc = (rule == 3) ? tgt : (rule == 4) ? pend_q[0] : 32'h0000_0000;
      obs[0] = bus.ctrl_signal_pc_o;
      obs[1] = bus.ctrl_signal_if_id_o;
      obs[2] = bus.ctrl_signal_id_ex_o;
      obs[3] = bus.ctrl_signal_muldiv_o;
      obs[4] = bus.ctrl_signal_ex_mem_o;
      obs[5] = bus.ctrl_signal_mem_wb_o;
      obs[6] = bus.ctrl_signal_icache_o;
      obs[7] = bus.ctrl_signal_dcache_o;
      for (int i = 0; i < 8; i++)
         check(names[i], 32'(obs[i]), 32'(row[15-2*i -: 2]));
      check("pc_new", bus.ctrl_to_pc_new_o, exp_pc);
      // Model state update at the coming edge
      case (rule)
         0: pend_q.delete();
         3: begin
               pend_q.delete();
               if (!ic_rdy) pend_q.push_back(tgt);
            end
         4: if (ic_rdy) pend_q.delete();
         default: ;
      endcase
   endtask

   initial begin
      rst = 1'b1;
      bus.ex_branch_flag_i   = 1'b0;
      bus.ex_pc_new_i        = '0;
      bus.icache_ready_i     = 1'b1;
      bus.dcache_ready_i     = 1'b1;
      bus.if_id_block_flag_i = 1'b0;
      bus.ex_block_flag_i    = 1'b0;
      bus.mem_block_flag_i   = 1'b0;
      bus.muldiv_ready_i     = 1'b1;

      // Reset with a branch present, then idle
      step(1, 1, 32'h80, 1, 1, 0, 0, 0);
      step(0, 0, 32'h0,  1, 1, 0, 0, 0);
      // Taken branch with icache ready, then idle
      step(0, 1, 32'h8000_0010, 1, 1, 0, 0, 0);
      step(0, 0, 32'h0, 1, 1, 0, 0, 0);
      // MEM stall masks a branch; branch taken once MEM frees
      step(0, 1, 32'h40, 1, 1, 0, 0, 1);
      step(0, 1, 32'h40, 1, 1, 0, 0, 0);
      // dcache not ready also counts as MEM stall
      step(0, 0, 32'h0, 1, 0, 0, 0, 0);
      // EX stall for three cycles
      repeat (3) step(0, 0, 32'h0, 1, 1, 0, 1, 0);
      // Branch while icache busy: redirect stays pending
      step(0, 1, 32'h200, 0, 1, 0, 0, 0);
      step(0, 0, 32'h0,   0, 1, 0, 0, 0);
      step(0, 0, 32'h0,   0, 1, 0, 0, 0);
      step(0, 0, 32'h0,   1, 1, 0, 0, 0);
      step(0, 0, 32'h0,   1, 1, 0, 0, 0);
      // Fetch stall only
      step(0, 0, 32'h0, 1, 1, 1, 0, 0);
      // Pending redirect held across EX stall, overwritten by a new branch
      step(0, 1, 32'h300, 0, 1, 0, 0, 0);
      step(0, 0, 32'h0,   0, 1, 0, 1, 0);
      step(0, 1, 32'h400, 0, 1, 0, 0, 0);
      step(0, 0, 32'h0,   0, 1, 0, 0, 0);
      // Reset mid-pend drops the redirect
      step(1, 0, 32'h0, 0, 1, 0, 0, 0);
      step(0, 0, 32'h0, 1, 1, 0, 0, 0);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 39) == 0),
              ($urandom_range(0, 3) == 0),
              $urandom & 32'hFFFF_FFFC,
              ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 9) != 0),
              ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 5) == 0));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
